// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM controller port between N_REQ requesters.
// Round-robin selection with an optional lock that lets the last owner keep
// the port across back-to-back accesses. Every transaction runs
// IDLE -> BUSY -> RELEASE. A watchdog aborts transactions the controller
// never completes, and all controller-facing signals are registered.
module sram_arbiter #(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = 21,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ-1:0]        req_lock,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ*16-1:0]     req_wdata,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        ack,
  output logic [15:0]             rdata,
  input  logic                    sram_idle,
  input  logic                    sram_ready,
  input  logic [15:0]             sram_rdata,
  output logic [ADDR_W-1:0]       data_addr,
  output logic                    read_data,
  output logic                    write_data,
  output logic [15:0]             data_out,
  output logic                    timeout_err
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CND_W = IDX_W + 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_REQ - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT   = WD_W'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] REQ_ZERO   = {N_REQ{1'b0}};
  localparam logic [N_REQ-1:0] REQ_ONE    = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [WD_W-1:0]    watchdog;

  logic [IDX_W-1:0]   winner;
  logic               found;
  logic [CND_W-1:0]   cand;
  logic [N_REQ-1:0]   win_onehot;
  logic [ADDR_W-1:0]  sel_addr;
  logic [15:0]        sel_wdata;
  logic               sel_we;

  // Winner selection: a locked previous owner with req still high keeps the
  // port; otherwise scan round-robin starting just after the last owner.
  always_comb begin
    winner = last_grant;
    found  = 1'b0;
    cand   = {CND_W{1'b0}};
    if (req_lock[last_grant] && req[last_grant]) begin
      winner = last_grant;
      found  = 1'b1;
    end else begin
      for (int k = 1; k <= N_REQ; k++) begin
        cand = {1'b0, last_grant} + CND_W'(k);
        if (cand >= CND_W'(N_REQ)) begin
          cand = cand - CND_W'(N_REQ);
        end else begin
          cand = cand;
        end
        if (!found && req[cand[IDX_W-1:0]]) begin
          winner = cand[IDX_W-1:0];
          found  = 1'b1;
        end else begin
          winner = winner;
        end
      end
    end
  end

  // Fields of the selected requester, captured on the IDLE -> BUSY step.
  always_comb begin
    win_onehot = REQ_ONE << winner;
    sel_addr   = req_addr[winner*ADDR_W +: ADDR_W];
    sel_wdata  = req_wdata[winner*16 +: 16];
    sel_we     = req_we[winner];
  end

  // Transaction FSM with all controller and requester outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= REQ_ZERO;
      ack         <= REQ_ZERO;
      rdata       <= 16'h0000;
      data_addr   <= {ADDR_W{1'b0}};
      read_data   <= 1'b0;
      write_data  <= 1'b0;
      data_out    <= 16'h0000;
      timeout_err <= 1'b0;
      last_grant  <= LAST_IDX;
      watchdog    <= {WD_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          ack        <= REQ_ZERO;
          if (sram_idle && (req != REQ_ZERO)) begin
            state      <= BUSY;
            grant      <= win_onehot;
            last_grant <= winner;
            watchdog   <= {WD_W{1'b0}};
            data_addr  <= sel_addr;
            data_out   <= sel_wdata;
            read_data  <= ~sel_we;
            write_data <= sel_we;
          end else begin
            state      <= IDLE;
            grant      <= REQ_ZERO;
            read_data  <= 1'b0;
            write_data <= 1'b0;
          end
        end
        BUSY: begin
          watchdog <= watchdog + WD_W'(1);
          if (sram_ready) begin
            // Writes leave the last read value visible to requesters.
            if (read_data) begin
              rdata <= sram_rdata;
            end else begin
              rdata <= rdata;
            end
            state      <= RELEASE;
            ack        <= grant;
            read_data  <= 1'b0;
            write_data <= 1'b0;
            data_addr  <= {ADDR_W{1'b0}};
            data_out   <= 16'h0000;
          end else if (watchdog == WD_LIMIT) begin
            // Controller never answered: abort, flag it, hand back zero data.
            timeout_err <= 1'b1;
            rdata       <= 16'h0000;
            state       <= RELEASE;
            ack         <= grant;
            read_data   <= 1'b0;
            write_data  <= 1'b0;
            data_addr   <= {ADDR_W{1'b0}};
            data_out    <= 16'h0000;
          end else begin
            state <= BUSY;
          end
        end
        RELEASE: begin
          // No arbitration here so an owner dropping req on ack is not re-granted.
          state <= IDLE;
          ack   <= REQ_ZERO;
          grant <= REQ_ZERO;
        end
        default: begin
          state      <= IDLE;
          grant      <= REQ_ZERO;
          ack        <= REQ_ZERO;
          read_data  <= 1'b0;
          write_data <= 1'b0;
          data_addr  <= {ADDR_W{1'b0}};
          data_out   <= 16'h0000;
          watchdog   <= {WD_W{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: a behavioural SRAM controller
// responder, an ack monitor feeding an observed queue, and per-scenario
// tasks that push expected completions and compare them in order.
module tb_sram_arbiter;

  localparam int N  = 3;
  localparam int AW = 21;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  req = '0, req_we = '0, req_lock = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*16-1:0] req_wdata = '0;
  logic [N-1:0]  grant, ack;
  logic [15:0]   rdata;
  logic          sram_idle = 1'b1, sram_ready = 1'b0;
  logic [15:0]   sram_rdata = 16'h0000;
  logic [AW-1:0] data_addr;
  logic          read_data, write_data, timeout_err;
  logic [15:0]   data_out;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [N-1:0] ack;
    logic [15:0]  rdata;
    int           cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];

  // Controller model behaviour knobs.
  bit  resp_en  = 1'b1;
  int  resp_lat = 1;
  int  busy_cnt = 0;
  int  cmd_cnt  = 0;

  sram_arbiter #(.N_REQ(N), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we), .req_lock(req_lock),
    .req_addr(req_addr), .req_wdata(req_wdata), .grant(grant), .ack(ack),
    .rdata(rdata), .sram_idle(sram_idle), .sram_ready(sram_ready),
    .sram_rdata(sram_rdata), .data_addr(data_addr), .read_data(read_data),
    .write_data(write_data), .data_out(data_out), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Controller responder: raise sram_ready in the resp_lat-th command cycle.
  always @(negedge clk) begin
    if (read_data || write_data) begin
      busy_cnt   = busy_cnt + 1;
      sram_ready = resp_en && (busy_cnt == resp_lat);
    end else begin
      busy_cnt   = 0;
      sram_ready = 1'b0;
    end
  end

  // Ack monitor: records each completion with the command length that preceded it.
  always @(posedge clk) begin
    ev_t ev;
    #1;
    if (reset) begin
      cmd_cnt = 0;
    end else begin
      if (read_data || write_data) cmd_cnt = cmd_cnt + 1;
      if (ack != '0) begin
        ev.ack = ack; ev.rdata = rdata; ev.cyc = cmd_cnt;
        obs_q.push_back(ev);
        cmd_cnt = 0;
      end
    end
  end

  task automatic push_exp(input logic [N-1:0] a, input logic [15:0] d, input int c);
    ev_t e;
    e.ack = a; e.rdata = d; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req = '0; req_we = '0; req_lock = '0; sram_idle = 1'b1; resp_en = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete(); obs_q.delete();
    @(negedge clk);
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (grant != '0) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_acks(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (obs_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; req = '0;
    repeat (2) @(negedge clk);
    total++; if (grant !== 3'b000) $display("FAIL reset_grant: got %b want 000", grant); else passed++;
    total++; if (ack !== 3'b000) $display("FAIL reset_ack: got %b want 000", ack); else passed++;
    total++; if (rdata !== 16'h0000) $display("FAIL reset_rdata: got %h want 0000", rdata); else passed++;
    total++; if ({data_addr, read_data, write_data, data_out} !== '0)
      $display("FAIL reset_cmd: got addr=%h rd=%b wr=%b dout=%h want all 0", data_addr, read_data, write_data, data_out);
    else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL reset_toerr: got %b want 0", timeout_err); else passed++;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (grant !== 3'b000) $display("FAIL reset_nogrant: got %b want 000", grant); else passed++;
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_single_read();
    bit ok; ev_t e, o;
    resp_lat = 3; sram_rdata = 16'hFFFB;
    req_addr[1*AW +: AW] = 21'h0000A; req_we = 3'b000;
    req = 3'b010;
    push_exp(3'b010, 16'hFFFB, 3);
    wait_grant(ok);
    total++; if (!ok) $display("FAIL read_grant_wait: got none want grant"); else passed++;
    total++; if (grant !== 3'b010) $display("FAIL read_grant: got %b want 010", grant); else passed++;
    total++; if (data_addr !== 21'h0000A || read_data !== 1'b1 || write_data !== 1'b0)
      $display("FAIL read_cmd: got addr=%h rd=%b wr=%b want 0000a 1 0", data_addr, read_data, write_data);
    else passed++;
    req = 3'b000;
    wait_acks(1, ok);
    total++; if (!ok) $display("FAIL read_ack_wait: got none want ack"); else passed++;
    total++; if (grant !== 3'b010 || ack !== 3'b010 || read_data !== 1'b0 || data_addr !== '0)
      $display("FAIL read_release: got grant=%b ack=%b rd=%b addr=%h want 010 010 0 0", grant, ack, read_data, data_addr);
    else passed++;
    @(negedge clk);
    total++; if (ack !== 3'b000 || grant !== 3'b000)
      $display("FAIL read_ack_pulse: got ack=%b grant=%b want 000 000", ack, grant);
    else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL read_sb_missing: got none want ack=%b", e.ack);
      else begin
        o = obs_q.pop_front();
        if (o.ack !== e.ack || o.rdata !== e.rdata || o.cyc != e.cyc)
          $display("FAIL read_sb: got ack=%b rdata=%h cyc=%0d want ack=%b rdata=%h cyc=%0d", o.ack, o.rdata, o.cyc, e.ack, e.rdata, e.cyc);
        else passed++;
      end
    end
  endtask

  task automatic test_round_robin();
    bit ok; ev_t e, o;
    do_reset();
    resp_lat = 1; sram_rdata = 16'h1234;
    push_exp(3'b001, 16'h1234, 1);
    push_exp(3'b010, 16'h1234, 1);
    push_exp(3'b100, 16'h1234, 1);
    push_exp(3'b001, 16'h1234, 1);
    req = 3'b111;
    wait_acks(4, ok);
    req = 3'b000;
    total++; if (!ok) $display("FAIL rr_wait: got %0d acks want 4", obs_q.size()); else passed++;
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL rr_sb_missing: got none want ack=%b", e.ack);
      else begin
        o = obs_q.pop_front();
        if (o.ack !== e.ack || o.rdata !== e.rdata || o.cyc != e.cyc)
          $display("FAIL rr_sb: got ack=%b rdata=%h cyc=%0d want ack=%b rdata=%h cyc=%0d", o.ack, o.rdata, o.cyc, e.ack, e.rdata, e.cyc);
        else passed++;
      end
    end
    total++; if (obs_q.size() != 0) $display("FAIL rr_extra: got %0d extra acks want 0", obs_q.size()); else passed++;
  endtask

  task automatic test_lock();
    bit ok; ev_t e, o;
    do_reset();
    resp_lat = 2; sram_rdata = 16'h0BEE;
    for (int i = 0; i < 4; i++) push_exp(3'b001, 16'h0BEE, 2);
    push_exp(3'b100, 16'h0BEE, 2);
    req = 3'b101; req_lock = 3'b001;
    wait_acks(4, ok);
    req_lock = 3'b000;
    total++; if (!ok) $display("FAIL lock_wait4: got %0d acks want 4", obs_q.size()); else passed++;
    wait_acks(5, ok);
    req = 3'b000;
    total++; if (!ok) $display("FAIL lock_wait5: got %0d acks want 5", obs_q.size()); else passed++;
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL lock_sb_missing: got none want ack=%b", e.ack);
      else begin
        o = obs_q.pop_front();
        if (o.ack !== e.ack || o.rdata !== e.rdata || o.cyc != e.cyc)
          $display("FAIL lock_sb: got ack=%b rdata=%h cyc=%0d want ack=%b rdata=%h cyc=%0d", o.ack, o.rdata, o.cyc, e.ack, e.rdata, e.cyc);
        else passed++;
      end
    end
  endtask

  task automatic test_write();
    bit ok; ev_t e, o;
    resp_lat = 4; sram_rdata = 16'hDEAD;
    req_addr[2*AW +: AW] = 21'h1FFFFE; req_wdata[2*16 +: 16] = 16'h7FFF;
    req_we = 3'b100; req = 3'b100;
    push_exp(3'b100, 16'h0BEE, 4);
    wait_grant(ok);
    total++; if (!ok || grant !== 3'b100) $display("FAIL wr_grant: got %b want 100", grant); else passed++;
    req = 3'b000; req_addr = '0; req_wdata = '0;
    @(negedge clk);
    total++; if (write_data !== 1'b1 || read_data !== 1'b0 || data_addr !== 21'h1FFFFE || data_out !== 16'h7FFF)
      $display("FAIL wr_cmd: got wr=%b rd=%b addr=%h dout=%h want 1 0 1ffffe 7fff", write_data, read_data, data_addr, data_out);
    else passed++;
    wait_acks(1, ok);
    total++; if (!ok) $display("FAIL wr_ack_wait: got none want ack"); else passed++;
    req_we = 3'b000;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL wr_sb_missing: got none want ack=%b", e.ack);
      else begin
        o = obs_q.pop_front();
        if (o.ack !== e.ack || o.rdata !== e.rdata || o.cyc != e.cyc)
          $display("FAIL wr_sb: got ack=%b rdata=%h cyc=%0d want ack=%b rdata=%h cyc=%0d", o.ack, o.rdata, o.cyc, e.ack, e.rdata, e.cyc);
        else passed++;
      end
    end
  endtask

  task automatic test_timeout();
    bit ok; ev_t e, o;
    @(negedge clk);
    resp_en = 1'b0; sram_rdata = 16'h5555;
    req = 3'b001;
    push_exp(3'b001, 16'h0000, TO);
    wait_grant(ok);
    req = 3'b000;
    wait_acks(1, ok);
    total++; if (!ok) $display("FAIL to_ack_wait: got none want ack"); else passed++;
    total++; if (timeout_err !== 1'b1) $display("FAIL to_err: got %b want 1", timeout_err); else passed++;
    @(negedge clk);
    resp_en = 1'b1; resp_lat = 2; sram_rdata = 16'h4321;
    req = 3'b010;
    push_exp(3'b010, 16'h4321, 2);
    wait_grant(ok);
    req = 3'b000;
    wait_acks(2, ok);
    total++; if (!ok) $display("FAIL to_next_wait: got %0d acks want 2", obs_q.size()); else passed++;
    total++; if (timeout_err !== 1'b1) $display("FAIL to_sticky: got %b want 1", timeout_err); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (obs_q.size() == 0) $display("FAIL to_sb_missing: got none want ack=%b", e.ack);
      else begin
        o = obs_q.pop_front();
        if (o.ack !== e.ack || o.rdata !== e.rdata || o.cyc != e.cyc)
          $display("FAIL to_sb: got ack=%b rdata=%h cyc=%0d want ack=%b rdata=%h cyc=%0d", o.ack, o.rdata, o.cyc, e.ack, e.rdata, e.cyc);
        else passed++;
      end
    end
  endtask

  task automatic test_idle_block();
    bit ok;
    @(negedge clk);
    sram_idle = 1'b0; resp_lat = 1;
    req = 3'b010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++; if (grant !== 3'b000 || read_data !== 1'b0)
        $display("FAIL idle_hold: got grant=%b rd=%b want 000 0", grant, read_data);
      else passed++;
    end
    sram_idle = 1'b1;
    wait_grant(ok);
    total++; if (!ok || grant !== 3'b010) $display("FAIL idle_release: got %b want 010", grant); else passed++;
    req = 3'b000;
    wait_acks(1, ok);
    obs_q.delete(); exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    resp_en = 1'b0;
    req = 3'b100;
    wait_grant(ok);
    req = 3'b000;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++; if (read_data !== 1'b0 || write_data !== 1'b0 || grant !== 3'b000 || data_addr !== '0)
      $display("FAIL rst_busy_cmd: got rd=%b wr=%b grant=%b addr=%h want 0 0 000 0", read_data, write_data, grant, data_addr);
    else passed++;
    total++; if (timeout_err !== 1'b0) $display("FAIL rst_busy_toerr: got %b want 0", timeout_err); else passed++;
    @(negedge clk);
    reset = 1'b0; resp_en = 1'b1; resp_lat = 1;
    @(negedge clk);
    total++; if (obs_q.size() != 0) $display("FAIL rst_busy_noack: got %0d acks want 0", obs_q.size()); else passed++;
    req = 3'b111;
    wait_grant(ok);
    req = 3'b000;
    total++; if (!ok || grant !== 3'b001) $display("FAIL rst_first_grant: got %b want 001", grant); else passed++;
    wait_acks(1, ok);
    total++; if (!ok) $display("FAIL rst_done_wait: got none want ack"); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_lock();
    test_write();
    test_timeout();
    test_idle_block();
    test_reset_mid_busy();
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single SRAM controller port between N_REQ requesters: send, scorer, loader, etc.
- Replaces per-module tri-state driving of read_data/data_addr with a muxed, registered round-robin grant.
- Each requester issues one word transaction per request. A lock input lets a requester hold the SRAM across back-to-back accesses, e.g. a senone dump.
- A watchdog aborts transactions the controller never completes.

Parameters:
N_REQ, 3, number of requesters (2..8); index 0 has first priority after reset
ADDR_W, 21, SRAM word/byte address width
TIMEOUT, 255, max cycles in BUSY waiting for sram_ready before abort (>=2)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
req  input  N_REQ  per-requester transaction request, level, held until ack
req_we  input  N_REQ  1=write, 0=read, per requester
req_lock  input  N_REQ  keep grant after completion while req stays high
req_addr  input  N_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  N_REQ*16  flattened write data (num, signed 16)
grant  output  N_REQ  one-hot, current owner during BUSY/RELEASE, 0 otherwise
ack  output  N_REQ  one-cycle completion pulse to owner
rdata  output  16  read data (num), valid in ack cycle, held until next ack
sram_idle  input  1  controller can accept a command
sram_ready  input  1  controller completed current command (read data valid)
sram_rdata  input  16  controller read data (num)
data_addr  output  ADDR_W  address to controller
read_data  output  1  read command, level
write_data  output  1  write command, level
data_out  output  16  write data to controller (num)
timeout_err  output  1  sticky abort flag, cleared only by reset

Behaviour:
- Reset, async: state=IDLE; grant, ack, rdata, data_addr, read_data, write_data, data_out, timeout_err all 0; last_grant=N_REQ-1; watchdog=0.
- State IDLE:
  - No command asserted.
  - If sram_idle=1 and req!=0, select winner and go to BUSY next cycle.
  - Winner: if req_lock[last_grant] & req[last_grant], winner=last_grant. Otherwise the first i with req[i] set, scanning last_grant+1, last_grant+2, ... modulo N_REQ.
  - On transition, register winner's addr, wdata and we into data_addr/data_out/command, set grant=onehot(winner), last_grant=winner, watchdog=0.
  - If sram_idle=0, wait in IDLE.
- State BUSY:
  - read_data = ~we, write_data = we, held level until sram_ready.
  - Address and data are stable, from registers; requester inputs are ignored after capture.
  - Watchdog increments each cycle.
  - On sram_ready=1: capture sram_rdata into rdata (reads only; writes leave rdata unchanged), go to RELEASE.
  - Else if watchdog==TIMEOUT-1: set timeout_err=1, rdata=0, go to RELEASE.
- State RELEASE (1 cycle):
  - Commands deasserted; data_addr and data_out return to 0.
  - ack=grant for this cycle only; grant still asserted.
  - No arbitration in this cycle, so the owner can drop req on ack without a duplicate grant.
  - Next state IDLE; grant cleared on exit.
- Latency: req sampled in IDLE (sram_idle=1) at cycle t → command from t+1. sram_ready at cycle k → ack at k+1 → earliest next command at k+3.
- Requester dropping req during BUSY: transaction still completes and ack is still pulsed; no cancellation.
- req_lock only affects selection at the next IDLE. A locked requester that drops req loses priority; rotation resumes from last_grant+1.
- All-zero req in IDLE: no state change, last_grant unchanged.
- sram_ready outside BUSY: ignored.
- Reset mid-BUSY: commands drop asynchronously; no ack is issued.

Test Plan:
- Single read: req[1]=1, we=0, addr=0x000A, sram_ready after 3 cycles with sram_rdata=-5 → read_data high exactly 3 cycles, ack[1] pulses 1 cycle with rdata=0xFFFB, grant=3'b010 during BUSY/RELEASE.
- Round-robin: req=3'b111 held after reset, each completing → grant order 0,1,2,0; no requester granted twice while another waits.
- Lock: req[0]=1 with req_lock[0]=1 for 4 transactions while req[2]=1 → four grants to 0, then 2 is granted once lock drops.
- Write: req[2] we=1, addr=0x1FFFFE, wdata=0x7FFF → write_data high, data_addr=0x1FFFFE, data_out=0x7FFF until sram_ready; rdata unchanged.
- Timeout (TIMEOUT=8): sram_ready never asserted → ack after 8 BUSY cycles, rdata=0, timeout_err=1 and stays 1 through later normal transactions until reset.
- sram_idle=0 with pending req → no grant until sram_idle=1. Async reset asserted mid-BUSY → all outputs 0 immediately; first grant after reset goes to requester 0.
